// File: rtl/mul_div_sequencer.sv
// mul_div_sequencer: multi-cycle MIPS multiply/divide controller that sits
// beside the EX-stage ALU and borrows it for one add or subtract per cycle.
// Multiply is shift-add and divide is restoring, both over {hi,lo}. The
// pipeline is stalled while the sequencer runs.
// Optional feature: define MD_SIGNED_EN for signed MULT/DIV. The extra
// SGN_PRE/SGN_POST states negate operands and results through the ALU.
// Without it, op[1] is ignored and MULT/DIV behave as MULTU/DIVU.
module mul_div_sequencer #(
    parameter int ITERS = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] alu_result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [2:0]  alu_ctrl,
    output logic        alu_own,
    output logic        busy,
    output logic        stall,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int               CNT_W     = $clog2(ITERS);
    localparam logic [CNT_W-1:0] LAST      = CNT_W'(ITERS - 1);
    localparam logic [2:0]       CTRL_ADD  = 3'b010;
    localparam logic [2:0]       CTRL_SUB  = 3'b110;
    localparam logic [2:0]       CTRL_NONE = 3'b000;

`ifdef MD_SIGNED_EN
    typedef enum logic [2:0] {IDLE, MUL, DIV, DONE, SGN_PRE, SGN_POST} state_t;
`else
    typedef enum logic [2:0] {IDLE, MUL, DIV, DONE} state_t;
`endif

    state_t           state;
    logic [31:0]      opnd;
    logic [CNT_W-1:0] count;
    logic [31:0]      sh;
    logic             div_take;
    logic             mul_carry;

`ifdef MD_SIGNED_EN
    logic is_mul;
    logic pre_a;
    logic pre_b;
    logic post_lo;
    logic post_hi;
    logic lo_zero;
`else
    logic unused_op1;
    assign unused_op1 = op[1];
`endif

    assign sh        = {hi[30:0], lo[31]};
    assign div_take  = hi[31] | (sh >= opnd);
    assign mul_carry = (alu_result < hi);
    assign stall     = busy | (start & (state == IDLE));

    // Drive the shared ALU operands and control only while the sequencer owns it
    always_comb begin
        alu_a    = '0;
        alu_b    = '0;
        alu_ctrl = CTRL_NONE;
        case (state)
            MUL: begin
                alu_a    = hi;
                alu_b    = lo[0] ? opnd : '0;
                alu_ctrl = CTRL_ADD;
            end
            DIV: begin
                alu_a    = sh;
                alu_b    = opnd;
                alu_ctrl = CTRL_SUB;
            end
`ifdef MD_SIGNED_EN
            SGN_PRE: begin
                alu_b    = pre_a ? lo : opnd;
                alu_ctrl = CTRL_SUB;
            end
            SGN_POST: begin
                if (post_lo) begin
                    alu_b    = lo;
                    alu_ctrl = CTRL_SUB;
                end else if (is_mul) begin
                    alu_a    = ~hi;
                    alu_b    = {31'b0, lo_zero};
                    alu_ctrl = CTRL_ADD;
                end else begin
                    alu_b    = hi;
                    alu_ctrl = CTRL_SUB;
                end
            end
`endif
            default: begin
                alu_a    = '0;
                alu_b    = '0;
                alu_ctrl = CTRL_NONE;
            end
        endcase
    end

    // Sequencer FSM: accept a request, iterate through the ALU, then pulse done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            hi      <= '0;
            lo      <= '0;
            opnd    <= '0;
            count   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            alu_own <= 1'b0;
`ifdef MD_SIGNED_EN
            is_mul  <= 1'b0;
            pre_a   <= 1'b0;
            pre_b   <= 1'b0;
            post_lo <= 1'b0;
            post_hi <= 1'b0;
            lo_zero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy  <= 1'b1;
                        hi    <= '0;
                        lo    <= src_a;
                        opnd  <= src_b;
                        count <= '0;
                        if (op[0] && (src_b == '0)) begin
                            hi    <= src_a;
                            lo    <= '1;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            alu_own <= 1'b1;
                            state   <= op[0] ? DIV : MUL;
`ifdef MD_SIGNED_EN
                            if (op[1] && (src_a[31] || src_b[31])) begin
                                state <= SGN_PRE;
                            end
`endif
                        end
`ifdef MD_SIGNED_EN
                        is_mul  <= ~op[0];
                        pre_a   <= op[1] & src_a[31];
                        pre_b   <= op[1] & src_b[31];
                        post_lo <= op[1] & (src_a[31] ^ src_b[31]);
                        post_hi <= op[1] & (op[0] ? src_a[31] : (src_a[31] ^ src_b[31]));
`endif
                    end
                end
                MUL, DIV: begin
                    if (state == MUL) begin
                        hi <= {mul_carry, alu_result[31:1]};
                        lo <= {alu_result[0], lo[31:1]};
                    end else if (div_take) begin
                        hi <= alu_result;
                        lo <= {lo[30:0], 1'b1};
                    end else begin
                        hi <= sh;
                        lo <= {lo[30:0], 1'b0};
                    end
                    count <= count + 1'b1;
                    if (count == LAST) begin
                        count <= '0;
`ifdef MD_SIGNED_EN
                        if (post_lo || post_hi) begin
                            state <= SGN_POST;
                        end else
`endif
                        begin
                            state   <= DONE;
                            done    <= 1'b1;
                            alu_own <= 1'b0;
                        end
                    end
                end
`ifdef MD_SIGNED_EN
                SGN_PRE: begin
                    if (pre_a) begin
                        lo    <= alu_result;
                        pre_a <= 1'b0;
                        if (!pre_b) begin
                            state <= is_mul ? MUL : DIV;
                        end
                    end else begin
                        opnd  <= alu_result;
                        pre_b <= 1'b0;
                        state <= is_mul ? MUL : DIV;
                    end
                end
                SGN_POST: begin
                    if (post_lo) begin
                        lo      <= alu_result;
                        lo_zero <= (lo == '0);
                        post_lo <= 1'b0;
                        if (!post_hi) begin
                            state   <= DONE;
                            done    <= 1'b1;
                            alu_own <= 1'b0;
                        end
                    end else begin
                        hi      <= alu_result;
                        post_hi <= 1'b0;
                        state   <= DONE;
                        done    <= 1'b1;
                        alu_own <= 1'b0;
                    end
                end
`endif
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    alu_own <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_div_sequencer.sv
// tb_mul_div_sequencer: table of multiply/divide vectors run through the
// sequencer with a behavioural ALU attached. Expected results go into a
// scoreboard queue when each request is driven. Hand-written sequences cover
// ignored starts and reset mid-operation.
module tb_mul_div_sequencer;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        logic [2:0]  ctrl;
        logic        own;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic [31:0] alu_result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_ctrl;
    logic        alu_own;
    logic        busy;
    logic        stall;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];
    vec_t vecs[$];

    mul_div_sequencer #(.ITERS(32)) dut (
        .clk(clk),
        .rst(rst),
        .start(start),
        .op(op),
        .src_a(src_a),
        .src_b(src_b),
        .alu_result(alu_result),
        .alu_a(alu_a),
        .alu_b(alu_b),
        .alu_ctrl(alu_ctrl),
        .alu_own(alu_own),
        .busy(busy),
        .stall(stall),
        .done(done),
        .hi(hi),
        .lo(lo)
    );

    // Free-running core clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the shared EX-stage ALU
    always_comb begin
        case (alu_ctrl)
            3'b010:  alu_result = alu_a + alu_b;
            3'b110:  alu_result = alu_a - alu_b;
            default: alu_result = '0;
        endcase
    end

    // Hard stop in case something wedges outside the bounded waits
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    function automatic vec_t mk(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] h, input logic [31:0] l, input int lat,
                                input logic [2:0] ctrl, input logic own);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.hi = h; v.lo = l;
        v.lat = lat; v.ctrl = ctrl; v.own = own;
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        #1;
        checkOutput("stall_cycle0", {31'b0, stall}, 32'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic runToDone(input logic [2:0] ctrl_exp, output int lat, output logic ctrl_bad,
                             output logic own_seen, output logic stall_bad);
        lat       = -1;
        ctrl_bad  = 1'b0;
        own_seen  = 1'b0;
        stall_bad = 1'b0;
        for (int c = 1; c <= 100; c++) begin
            @(negedge clk);
            if (alu_own) begin
                own_seen = 1'b1;
                if (ctrl_exp != 3'b000 && alu_ctrl !== ctrl_exp) ctrl_bad = 1'b1;
            end
            if (stall !== 1'b1) stall_bad = 1'b1;
            if (done === 1'b1) begin
                lat = c;
                break;
            end
        end
    endtask

    initial begin
        logic [63:0] prod;
        logic [31:0] da;
        logic [31:0] db;
        exp_t        e;
        int          lat;
        logic        ctrl_bad;
        logic        own_seen;
        logic        stall_bad;
        logic        busy34;
        logic        saw_done;

        vecs.push_back(mk(2'b00, 32'd7, 32'd6, 32'd0, 32'd42, 33, 3'b010, 1'b1));
        vecs.push_back(mk(2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 33, 3'b010, 1'b1));
        vecs.push_back(mk(2'b01, 32'd100, 32'd7, 32'd2, 32'd14, 33, 3'b110, 1'b1));
        vecs.push_back(mk(2'b01, 32'h80000000, 32'd1, 32'd0, 32'h80000000, 33, 3'b110, 1'b1));
        vecs.push_back(mk(2'b01, 32'd1234, 32'd0, 32'd1234, 32'hFFFFFFFF, 1, 3'b000, 1'b0));
        vecs.push_back(mk(2'b01, 32'd5, 32'd9, 32'd5, 32'd0, 33, 3'b110, 1'b1));
        vecs.push_back(mk(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd1, 33, 3'b110, 1'b1));
        da = 32'h12345678; db = 32'h9ABCDEF0;
        prod = {32'h0, da} * {32'h0, db};
        vecs.push_back(mk(2'b00, da, db, prod[63:32], prod[31:0], 33, 3'b010, 1'b1));
        da = 32'hDEADBEEF; db = 32'h00001234;
        vecs.push_back(mk(2'b01, da, db, da % db, da / db, 33, 3'b110, 1'b1));
        vecs.push_back(mk(2'b00, 32'd0, 32'hFFFFFFFF, 32'd0, 32'd0, 33, 3'b010, 1'b1));
`ifdef MD_SIGNED_EN
        vecs.push_back(mk(2'b10, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1, 36, 3'b000, 1'b1));
        vecs.push_back(mk(2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 36, 3'b000, 1'b1));
`else
        vecs.push_back(mk(2'b10, 32'hFFFFFFFD, 32'd5, 32'h00000004, 32'hFFFFFFF1, 33, 3'b010, 1'b1));
        vecs.push_back(mk(2'b11, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 33, 3'b110, 1'b1));
`endif

        rst   = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        src_a = '0;
        src_b = '0;

        #12;
        checkOutput("reset_hi", hi, 32'd0);
        checkOutput("reset_lo", lo, 32'd0);
        checkOutput("reset_busy", {31'b0, busy}, 32'd0);
        checkOutput("reset_done", {31'b0, done}, 32'd0);
        checkOutput("reset_own", {31'b0, alu_own}, 32'd0);
        checkOutput("reset_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            e.hi = vecs[i].hi; e.lo = vecs[i].lo; e.lat = vecs[i].lat;
            sb.push_back(e);
            applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b);
            runToDone(vecs[i].ctrl, lat, ctrl_bad, own_seen, stall_bad);
            checkOutput("sb_nonempty", 32'(sb.size()), 32'd1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checkOutput($sformatf("v%0d_latency", i), 32'(lat), 32'(e.lat));
                checkOutput($sformatf("v%0d_hi", i), hi, e.hi);
                checkOutput($sformatf("v%0d_lo", i), lo, e.lo);
            end
            checkOutput($sformatf("v%0d_alu_ctrl", i), {31'b0, ctrl_bad}, 32'd0);
            checkOutput($sformatf("v%0d_alu_own", i), {31'b0, own_seen}, {31'b0, vecs[i].own});
            checkOutput($sformatf("v%0d_stall_run", i), {31'b0, stall_bad}, 32'd0);
            @(negedge clk);
            checkOutput($sformatf("v%0d_done_pulse", i), {31'b0, done}, 32'd0);
            checkOutput($sformatf("v%0d_stall_after", i), {31'b0, stall}, 32'd0);
            checkOutput($sformatf("v%0d_hold_lo", i), lo, vecs[i].lo);
        end

        // start pulses at cycles 5 and 20 while a MULTU runs must be ignored
        e.hi = 32'd0; e.lo = 32'd42; e.lat = 33;
        sb.push_back(e);
        applyStimulus(2'b00, 32'd7, 32'd6);
        lat    = -1;
        busy34 = 1'b1;
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (done === 1'b1 && lat < 0) lat = c;
            if (c == 34) busy34 = busy;
            start = (c == 5 || c == 20);
            op    = 2'b01;
            src_a = 32'd99;
            src_b = 32'd3;
        end
        start = 1'b0;
        e = sb.pop_front();
        checkOutput("ign_latency", 32'(lat), 32'(e.lat));
        checkOutput("ign_hi", hi, e.hi);
        checkOutput("ign_lo", lo, e.lo);
        checkOutput("ign_busy_c34", {31'b0, busy34}, 32'd0);

        // Reset in cycle 10 of an operation aborts it with no done pulse
        applyStimulus(2'b00, 32'd7, 32'd6);
        for (int c = 1; c <= 10; c++) begin
            @(negedge clk);
        end
        rst = 1'b0;
        #1;
        checkOutput("abort_hi", hi, 32'd0);
        checkOutput("abort_lo", lo, 32'd0);
        checkOutput("abort_busy", {31'b0, busy}, 32'd0);
        checkOutput("abort_own", {31'b0, alu_own}, 32'd0);
        checkOutput("abort_stall", {31'b0, stall}, 32'd0);
        @(negedge clk);
        rst      = 1'b1;
        saw_done = 1'b0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (done === 1'b1) saw_done = 1'b1;
        end
        checkOutput("abort_no_done", {31'b0, saw_done}, 32'd0);
        checkOutput("abort_lo_after", lo, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
